// File: rtl/vga_scaled_window_addr.sv
// Framebuffer read-address generator: centres a 1x / 2^k-up / 2^k-down scaled image on screen.
// Optional macro WINDOW_BORDER_EN adds a one-pixel `border` output around the window.
`timescale 1ns/1ps
module vga_scaled_window_addr #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 19
) (
    input  logic               clock,
    input  logic               vga_reset,
    input  logic [COORD_W-1:0] next_x,
    input  logic [COORD_W-1:0] next_y,
    input  logic               mode_valid,
    input  logic [1:0]         mode_sel,
    input  logic [1:0]         mode_log2,
    output logic               mode_ack,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               in_image,
    output logic [COORD_W-1:0] win_w,
    output logic [COORD_W-1:0] win_h
`ifdef WINDOW_BORDER_EN
    ,
    output logic               border
`endif
);

    // Size arithmetic gets headroom for an 8x upscale before clamping.
    localparam int DW  = COORD_W + 4;
    localparam int CW1 = COORD_W + 1;

    localparam logic [DW-1:0]      IMG_W_D  = DW'(IMG_W);
    localparam logic [DW-1:0]      IMG_H_D  = DW'(IMG_H);
    localparam logic [DW-1:0]      SCR_W_D  = DW'(SCR_W);
    localparam logic [DW-1:0]      SCR_H_D  = DW'(SCR_H);
    localparam logic [CW1-1:0]     SCR_W_E  = CW1'(SCR_W);
    localparam logic [CW1-1:0]     SCR_H_E  = CW1'(SCR_H);
    localparam logic [COORD_W-1:0] XOFF_RST = COORD_W'((SCR_W - IMG_W) / 2);
    localparam logic [COORD_W-1:0] YOFF_RST = COORD_W'((SCR_H - IMG_H) / 2);

    function automatic logic [DW-1:0] scale_dim(
        input logic [DW-1:0] img,
        input logic [DW-1:0] scr,
        input logic [1:0]    sel,
        input logic [1:0]    k
    );
        logic [DW-1:0] v;
        case (sel)
            2'd1:    v = img << k;
            2'd2:    v = img >> k;
            default: v = img;
        endcase
        return (v > scr) ? scr : ((v == '0) ? {{(DW-1){1'b0}}, 1'b1} : v);
    endfunction

    logic               pend_r;
    logic [1:0]         pend_sel_r;
    logic [1:0]         pend_log2_r;
    logic [1:0]         act_sel_r;
    logic [1:0]         act_log2_r;
    logic               mode_ack_r;
    logic [COORD_W-1:0] win_w_r;
    logic [COORD_W-1:0] win_h_r;
    logic [COORD_W-1:0] xoff_r;
    logic [COORD_W-1:0] yoff_r;
    logic               s1_in_r;
    logic [COORD_W-1:0] s1_dx_r;
    logic [COORD_W-1:0] s1_dy_r;
    logic [COORD_W-1:0] s1_w_r;
    logic [ADDR_W-1:0]  rd_addr_r;
    logic               in_image_r;

    logic               boundary_s;
    logic [DW-1:0]      w_full_s;
    logic [DW-1:0]      h_full_s;
    logic [DW-1:0]      xoff_full_s;
    logic [DW-1:0]      yoff_full_s;
    logic [CW1-1:0]     x_e_s;
    logic [CW1-1:0]     y_e_s;
    logic [CW1-1:0]     xo_e_s;
    logic [CW1-1:0]     yo_e_s;
    logic [CW1-1:0]     w_e_s;
    logic [CW1-1:0]     h_e_s;
    logic               in_x_s;
    logic               in_y_s;
    logic [ADDR_W-1:0]  addr_s;

    // Frame boundary detect, next window geometry, and the S1 window compare.
    always_comb begin
        boundary_s  = (next_x == '0) && (next_y == '0);
        w_full_s    = scale_dim(IMG_W_D, SCR_W_D, act_sel_r, act_log2_r);
        h_full_s    = scale_dim(IMG_H_D, SCR_H_D, act_sel_r, act_log2_r);
        xoff_full_s = (SCR_W_D - w_full_s) >> 1'b1;
        yoff_full_s = (SCR_H_D - h_full_s) >> 1'b1;
        x_e_s       = {1'b0, next_x};
        y_e_s       = {1'b0, next_y};
        xo_e_s      = {1'b0, xoff_r};
        yo_e_s      = {1'b0, yoff_r};
        w_e_s       = {1'b0, win_w_r};
        h_e_s       = {1'b0, win_h_r};
        in_x_s      = (x_e_s >= xo_e_s) && (x_e_s < xo_e_s + w_e_s) && (x_e_s < SCR_W_E);
        in_y_s      = (y_e_s >= yo_e_s) && (y_e_s < yo_e_s + h_e_s) && (y_e_s < SCR_H_E);
        addr_s      = ADDR_W'(s1_dy_r) * ADDR_W'(s1_w_r) + ADDR_W'(s1_dx_r);
    end

    // Mode request capture and frame-boundary apply; a boundary-cycle request waits a frame.
    always_ff @(posedge clock) begin
        if (!vga_reset) begin
            pend_r      <= 1'b0;
            pend_sel_r  <= 2'd0;
            pend_log2_r <= 2'd0;
            act_sel_r   <= 2'd0;
            act_log2_r  <= 2'd0;
            mode_ack_r  <= 1'b0;
        end else begin
            mode_ack_r <= boundary_s && pend_r;
            if (boundary_s && pend_r) begin
                act_sel_r  <= pend_sel_r;
                act_log2_r <= pend_log2_r;
            end
            if (mode_valid) begin
                pend_r      <= 1'b1;
                pend_sel_r  <= mode_sel;
                pend_log2_r <= mode_log2;
            end else if (boundary_s) begin
                pend_r <= 1'b0;
            end
        end
    end

    // Window size and centring offsets, one cycle behind the active mode.
    always_ff @(posedge clock) begin
        if (!vga_reset) begin
            win_w_r <= COORD_W'(IMG_W);
            win_h_r <= COORD_W'(IMG_H);
            xoff_r  <= XOFF_RST;
            yoff_r  <= YOFF_RST;
        end else begin
            win_w_r <= COORD_W'(w_full_s);
            win_h_r <= COORD_W'(h_full_s);
            xoff_r  <= COORD_W'(xoff_full_s);
            yoff_r  <= COORD_W'(yoff_full_s);
        end
    end

    // S1 registers; the width travels with the pixel so a mid-pipe geometry change stays consistent.
    always_ff @(posedge clock) begin
        if (!vga_reset) begin
            s1_in_r <= 1'b0;
            s1_dx_r <= '0;
            s1_dy_r <= '0;
            s1_w_r  <= '0;
        end else begin
            s1_in_r <= in_x_s && in_y_s;
            s1_dx_r <= next_x - xoff_r;
            s1_dy_r <= next_y - yoff_r;
            s1_w_r  <= win_w_r;
        end
    end

    // S2 registers: linear address, forced to zero outside the window.
    always_ff @(posedge clock) begin
        if (!vga_reset) begin
            rd_addr_r  <= '0;
            in_image_r <= 1'b0;
        end else begin
            rd_addr_r  <= s1_in_r ? addr_s : '0;
            in_image_r <= s1_in_r;
        end
    end

    assign mode_ack = mode_ack_r;
    assign rd_addr  = rd_addr_r;
    assign in_image = in_image_r;
    assign win_w    = win_w_r;
    assign win_h    = win_h_r;

`ifdef WINDOW_BORDER_EN
    localparam logic [CW1-1:0] ONE_E = {{COORD_W{1'b0}}, 1'b1};

    logic bx_s;
    logic by_s;
    logic border_s;
    logic s1_border_r;
    logic border_r;

    // Ring one pixel outside the window; an axis filling the screen has no ring on that axis.
    always_comb begin
        bx_s = (w_e_s < SCR_W_E)
             ? ((x_e_s + ONE_E >= xo_e_s) && (x_e_s < xo_e_s + w_e_s + ONE_E)) : in_x_s;
        by_s = (h_e_s < SCR_H_E)
             ? ((y_e_s + ONE_E >= yo_e_s) && (y_e_s < yo_e_s + h_e_s + ONE_E)) : in_y_s;
        border_s = bx_s && by_s && !(in_x_s && in_y_s);
    end

    // Border flag pipelined alongside in_image.
    always_ff @(posedge clock) begin
        if (!vga_reset) begin
            s1_border_r <= 1'b0;
            border_r    <= 1'b0;
        end else begin
            s1_border_r <= border_s;
            border_r    <= s1_border_r;
        end
    end

    assign border = border_r;
`endif

endmodule
